// File: rtl/ifill_responder_pkg.sv
// Shared cache package: line format constants, fill FSM state encoding
// and the line-alignment helper used by the instruction fill path.
package ifill_responder_pkg;

  localparam int ADDR_W     = 64;
  localparam int LINE_W     = 512;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W = 3;
  localparam int LINE_OFF_W = $clog2(LINE_W / 8);

  typedef logic [ADDR_W-1:0] line_addr_t;

  // Fill FSM encoding kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BEAT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic line_addr_t lineAlign(input line_addr_t addr);
    return {addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ifill_responder_line_assembler.sv
// Line assembly register: writes one memory beat into its slot of the
// fill line and holds the line until overwritten.
module ifill_responder_line_assembler #(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic              we_i,
  output logic [LINE_W-1:0] line_o
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (we_i) begin
      line_q[int'(index_i)*BEAT_W +: BEAT_W] <= beat_i;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/ifill_responder.sv
// Instruction-cache miss responder: accepts a miss, issues one memory
// read for the aligned line, assembles the returned beats and delivers it.
module ifill_responder #(
  parameter int LINE_W = ifill_responder_pkg::LINE_W,
  parameter int BEAT_W = ifill_responder_pkg::BEAT_W,
  parameter int BEATS  = ifill_responder_pkg::BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irequest,
  output logic              ireqack,
  input  logic [63:0]       iaddr,
  output logic [LINE_W-1:0] idata,
  output logic              idone,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata
);

  import ifill_responder_pkg::*;

  logic [1:0]            state_q, state_d;
  line_addr_t            addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  beat_we;

  // Beats are only accepted in BEAT; strays elsewhere (incl. the grant
  // cycle) fall through untouched. The counter stops at the last beat.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    beat_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (irequest) begin
          addr_d  = lineAlign(iaddr);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (mem_rvalid) begin
          beat_we = 1'b1;
          if (cnt_q == BEAT_CNT_W'(BEATS - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ireqack  = (state_q == ST_IDLE) && irequest;
  assign mem_req  = (state_q == ST_REQ);
  assign idone    = (state_q == ST_DONE);
  assign mem_addr = addr_q;

  ifill_responder_line_assembler #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (BEAT_CNT_W)
  ) u_line_assembler (
    .clk     (clk),
    .rst_n   (rst_n),
    .beat_i  (mem_rdata),
    .index_i (cnt_q),
    .we_i    (beat_we),
    .line_o  (idata)
  );

endmodule

// File: tb/tb_ifill_responder.sv
// Directed table-driven bench for ifill_responder plus hand sequences for
// back-to-back requests and reset in the middle of a fill.
module tb_ifill_responder;

  import ifill_responder_pkg::*;

  typedef struct {
    logic [63:0] addr;
    int          gntDelay;
    int          beatGap;
    bit          stray;
    logic [63:0] seed;
    logic [63:0] expAddr;
    int          expLatency;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              irequest;
  logic              ireqack;
  logic [63:0]       iaddr;
  logic [LINE_W-1:0] idata;
  logic              idone;
  logic              mem_req;
  logic [63:0]       mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int ackCycle = 0;
  int doneCycle = 0;

  vec_t vecs [5];

  ifill_responder #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irequest   (irequest),
    .ireqack    (ireqack),
    .iaddr      (iaddr),
    .idata      (idata),
    .idone      (idone),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete fill; inputs change just after negedge, outputs sampled 1 unit later.
  task automatic applyStimulus(input vec_t v, input bit keepReq, input logic [63:0] nextAddr);
    logic [511:0] expLine;
    int n;
    expLine = '0;
    irequest = 1'b1;
    iaddr = v.addr;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    checkOutput("ireqack", ireqack, 1);
    checkOutput("mem_req in ack cycle", mem_req, 0);
    ackCycle = cycle;
    @(negedge clk);
    irequest = keepReq;
    iaddr = nextAddr;
    for (int i = 0; i <= v.gntDelay; i++) begin
      mem_gnt = (i == v.gntDelay);
      mem_rvalid = v.stray && (i == v.gntDelay);
      mem_rdata = 64'hDEAD;
      #1;
      checkOutput("mem_req", mem_req, 1);
      checkOutput("mem_addr", mem_addr, v.expAddr);
      checkOutput("ireqack in REQ", ireqack, 0);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      for (int g = 0; g < v.beatGap; g++) begin
        mem_rvalid = 1'b0;
        #1;
        checkOutput("idone during gap", idone, 0);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata = v.seed + 64'(k);
      expLine[k*BEAT_W +: BEAT_W] = v.seed + 64'(k);
      #1;
      checkOutput("idone during beat", idone, 0);
      checkOutput("mem_req during beat", mem_req, 0);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    #1;
    n = 0;
    while (idone !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("idone", idone, 1);
    doneCycle = cycle;
    checkOutput("latency", doneCycle - ackCycle, v.expLatency);
    checkOutput("idata", idata, expLine);
    checkOutput("mem_req in DONE", mem_req, 0);
    checkOutput("ireqack in DONE", ireqack, 0);
    @(negedge clk);
    #1;
    checkOutput("idone single pulse", idone, 0);
  endtask

  initial begin
    vec_t vA, vB, vR;
    int doneA;
    bit sawDone;

    // addr, gntDelay, beatGap, stray, seed, expAddr, expLatency
    vecs[0] = '{64'h1040, 0, 0, 1'b0, 64'h1, 64'h1040, 10};
    vecs[1] = '{64'h1047, 0, 0, 1'b0, 64'h100, 64'h1040, 10};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 5, 2, 1'b0, 64'hA0, 64'hFFFF_FFFF_FFFF_FFC0, 31};
    vecs[3] = '{64'h2000_003F, 0, 0, 1'b1, 64'h55000, 64'h2000_0000, 10};
    vecs[4] = '{64'h80, 1, 1, 1'b1, 64'h10, 64'h80, 19};

    rst_n = 1'b0;
    irequest = 1'b0;
    iaddr = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    #2;
    checkOutput("reset ireqack", ireqack, 0);
    checkOutput("reset idone", idone, 0);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset idata", idata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d addr=%0h", i, vecs[i].addr);
      applyStimulus(vecs[i], 1'b0, 64'hBAD0_0000_0000_0000);
      if (i == 0) begin
        checkOutput("basic idata[63:0]", idata[63:0], 64'h1);
        checkOutput("basic idata[511:448]", idata[511:448], 64'h8);
      end
      @(negedge clk);
    end

    $display("[TB] back-to-back requests");
    vA = '{64'h4000, 0, 0, 1'b0, 64'h1000, 64'h4000, 10};
    vB = '{64'h5010, 0, 0, 1'b0, 64'h2000, 64'h5000, 10};
    applyStimulus(vA, 1'b1, vB.addr);
    doneA = doneCycle;
    applyStimulus(vB, 1'b0, 64'h0);
    checkOutput("back-to-back ack cycle", ackCycle - doneA, 1);
    @(negedge clk);

    $display("[TB] reset mid-fill");
    irequest = 1'b1;
    iaddr = 64'h3000;
    #1;
    checkOutput("mid-fill ireqack", ireqack, 1);
    @(negedge clk);
    irequest = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 64'hBEEF0 + 64'(k);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset ireqack", ireqack, 0);
    checkOutput("mid reset idone", idone, 0);
    checkOutput("mid reset mem_req", mem_req, 0);
    checkOutput("mid reset mem_addr", mem_addr, 0);
    checkOutput("mid reset idata", idata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (idone) sawDone = 1'b1;
    end
    checkOutput("no idone after reset", sawDone, 0);
    @(negedge clk);
    vR = '{64'h6008, 0, 0, 1'b0, 64'h7000, 64'h6000, 10};
    applyStimulus(vR, 1'b0, 64'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifill_responder.md
IFILL_RESPONDER -- requirements
Module: ifill_responder

Interface
REQ-001 Parameters (name, default, meaning): LINE_W, 512, fill line width in bits; BEAT_W, 64, memory beat width in bits; BEATS, LINE_W/BEAT_W = 8, beats per line.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- irequest  in  1  cache miss request, held until acked.
- ireqack  out  1  one-cycle pulse; request and address accepted.
- iaddr  in  64  miss line address.
- idata  out  LINE_W  assembled line; valid only while idone=1.
- idone  out  1  one-cycle pulse; line delivered.
- mem_req  out  1  memory read request.
- mem_addr  out  64  line-aligned memory address.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  BEAT_W  read beat, ascending word order.

Function
REQ-003 States SHALL be IDLE, REQ, BEAT and DONE.
REQ-004 IDLE: when irequest=1, latch iaddr with bits [5:0] forced to 0, pulse ireqack for exactly one cycle, go to REQ.
REQ-005 REQ: mem_req=1 and mem_addr=latched address, held stable until a cycle with mem_gnt=1; then go to BEAT with beat counter=0.
REQ-006 mem_rvalid in IDLE, REQ or DONE SHALL be ignored, including in the grant cycle itself.
REQ-007 BEAT: each mem_rvalid=1 cycle stores mem_rdata into idata bits [k*BEAT_W +: BEAT_W], where k is the beat counter, then increments the counter; gaps between beats are allowed.
REQ-008 After beat BEATS-1 is stored, go to DONE on the next edge; the beat counter is 3 bits and SHALL NOT wrap within a fill.
REQ-009 DONE: idone=1 for exactly one cycle with idata holding the full line; return to IDLE.
REQ-010 Miss latency: from the ireqack cycle, idone SHALL occur no earlier than 1 (REQ) + 1 (grant) + BEATS cycles, i.e. at least 10 cycles with zero-wait memory.
REQ-011 A request arriving while not in IDLE SHALL NOT be acked until IDLE. An irequest still high in the cycle after idone SHALL be accepted as a new request.
REQ-012 iaddr changes after ireqack SHALL have no effect on the fill in progress.
REQ-013 idata SHALL keep its last value outside DONE; consumers use it only with idone=1.
REQ-014 ireqack, idone and mem_req SHALL never assert in the same cycle.

Reset
REQ-015 On rst_n=0 (asynchronous): state=IDLE, ireqack=0, idone=0, mem_req=0, mem_addr=0, idata=0, beat counter=0, latched address=0.
REQ-016 Reset mid-fill SHALL abandon the fill with no idone; after release, the first irequest starts a clean fill.

Structure
REQ-017 The state enum and the LINE_W, BEAT_W and BEATS constants SHALL live in the shared cache package beside the existing cache line-format definitions.
REQ-018 Single module; the line-assembly shift/insert register MAY be split into sub-module line_assembler (inputs: beat, index, write-enable; output: line).

Verification
REQ-019 Basic fill: irequest with iaddr=0x1040; zero-wait memory with beats 0x1..0x8 -> ireqack one cycle; mem_addr=0x1040; idone 10 cycles after ack; idata[63:0]=0x1, idata[511:448]=0x8.
REQ-020 Unaligned address: iaddr=0x1047 -> mem_addr=0x1040.
REQ-021 Stalls: mem_gnt delayed 5 cycles and beats with 2-cycle gaps -> mem_req and mem_addr stable throughout; single idone; data order correct.
REQ-022 Stray beat: mem_rvalid=1 in the grant cycle with value 0xDEAD -> value absent from idata; exactly 8 beats captured.
REQ-023 Back-to-back: irequest held high across idone -> second ireqack in the cycle after idone; second fill independent.
REQ-024 Reset after beat 4 -> no idone; all outputs 0; a following request completes normally.
